feeder_ctrl: RTL and testbench

//  Sequences the feeding-wheel mechanism. Accepts feed requests (external pulses or an internal

---
 rtl/feeder_pkg.sv | 14 +
 rtl/feeder_tick_timer.sv | 29 ++
 rtl/feeder_ctrl.sv | 148 ++++++++++++++
 tb/tb_feeder_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared types and widths for the feeding-wheel controller.
package feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPIN,
        PARK,
        EMPTY,
        FAULT
    } feeder_state_t;

    localparam int FED_CNT_W = 16;

endpackage

// File: rtl/feeder_tick_timer.sv
// Interval timer: counts enabled ticks while auto_en is high and fires once
// every INTERVAL ticks; dropping auto_en returns it to the start of an interval.
module feeder_tick_timer #(
    parameter int INTERVAL = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic auto_en,
    output logic timer_fire
);

    localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(INTERVAL - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || !auto_en) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign timer_fire = auto_en & en & (cnt == LAST);

endmodule

// File: rtl/feeder_ctrl.sv
// Feeding-wheel sequencer: queues feed requests, spins the wheel for exactly one
// portion, parks on the next sensor rising edge, and flags empty hopper / stuck wheel.
module feeder_ctrl
    import feeder_pkg::*;
#(
    parameter int PERIOD   = 65536,
    parameter int TIMEOUT  = 2 * PERIOD,
    parameter int INTERVAL = 1000000,
    parameter int MAX_PEND = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            req,
    input  logic                            auto_en,
    input  logic                            clr,
    input  logic                            revolution,
    input  logic                            remain,
    input  logic                            feed,
    output logic                            motor,
    output logic                            busy,
    output logic                            done,
    output logic                            empty,
    output logic                            fault,
    output logic                            ovf,
    output logic [$clog2(MAX_PEND+1)-1:0]   pending,
    output logic [FED_CNT_W-1:0]            fed_count
);

    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam int TO_W   = $clog2(TIMEOUT);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
    localparam logic [TO_W-1:0]   TO_LOAD  = TO_W'(TIMEOUT - 1);

    feeder_state_t   state;
    feeder_state_t   next_state;
    logic [TO_W-1:0] to_cnt;
    logic            to_zero;
    logic            rev_prev;
    logic            rev_rise;
    logic            timer_fire;
    logic            inc;
    logic            dispatch;
    logic            lost;
    logic            motor_d;
    logic            busy_d;
    logic            done_d;
    logic            empty_d;
    logic            fault_d;

    feeder_tick_timer #(
        .INTERVAL (INTERVAL)
    ) u_tick_timer (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .auto_en    (auto_en),
        .timer_fire (timer_fire)
    );

    assign rev_rise = revolution & ~rev_prev;
    assign to_zero  = (to_cnt == '0);
    assign inc      = req | timer_fire;
    assign dispatch = (state == IDLE) && en && (pending != '0) && remain;
    assign lost     = inc && !dispatch && (pending == PEND_MAX);

    // State register; the outputs are registered alongside it so motor never
    // sees a combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            motor <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            empty <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= next_state;
            motor <= motor_d;
            busy  <= busy_d;
            done  <= done_d;
            empty <= empty_d;
            fault <= fault_d;
        end
    end

    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    always_comb begin
        next_state = state;
        if (en) begin
            case (state)
                IDLE:    if (pending != '0) next_state = remain ? SPIN : EMPTY;
                SPIN:    if (feed) next_state = PARK;
                         else if (to_zero) next_state = FAULT;
                PARK:    if (rev_rise) next_state = IDLE;
                         else if (to_zero) next_state = FAULT;
                EMPTY:   if (remain) next_state = IDLE;
                FAULT:   if (clr) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs are derived from the state being entered, so they line up with it.
    always_comb begin
        motor_d = (next_state == SPIN) || (next_state == PARK);
        busy_d  = motor_d;
        done_d  = (state == PARK) && (next_state == IDLE);
        empty_d = (next_state == EMPTY);
        fault_d = (next_state == FAULT);
    end

    // Request queue: captured every clk; a simultaneous dispatch cancels the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            if (inc && !dispatch) begin
                if (pending != PEND_MAX) pending <= pending + 1'b1;
            end else if (dispatch && !inc) begin
                pending <= pending - 1'b1;
            end

            if (lost) ovf <= 1'b1;
            else if (en && clr) ovf <= 1'b0;
        end
    end

    // Stuck-wheel guard spans SPIN and PARK together; sensor edge history and
    // portion count only move on enabled ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt    <= TO_LOAD;
            rev_prev  <= 1'b0;
            fed_count <= '0;
        end else if (en) begin
            rev_prev <= revolution;
            if (dispatch) begin
                to_cnt <= TO_LOAD;
            end else if (((state == SPIN) || (state == PARK)) && !to_zero) begin
                to_cnt <= to_cnt - 1'b1;
            end
            if ((state == SPIN) && feed) fed_count <= fed_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_feeder_ctrl.sv
// Closed-loop bench for feeder_ctrl with a 16-position wheel model that drops a
// portion at position 4 and raises the revolution sensor on positions 8..15.
module tb_feeder_ctrl;
    import feeder_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 req;
    logic                 auto_en;
    logic                 clr;
    logic                 revolution;
    logic                 remain;
    logic                 feed;
    logic                 motor;
    logic                 busy;
    logic                 done;
    logic                 empty;
    logic                 fault;
    logic                 ovf;
    logic [1:0]           pending;
    logic [FED_CNT_W-1:0] fed_count;

    int vectors     = 0;
    int miscompares = 0;
    int pos         = 0;
    int portions    = 2;
    bit wheel_on    = 1'b1;
    int spin_ticks  = 0;
    bit faulted     = 1'b0;

    feeder_ctrl #(
        .PERIOD   (16),
        .TIMEOUT  (32),
        .INTERVAL (40),
        .MAX_PEND (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .auto_en    (auto_en),
        .clr        (clr),
        .revolution (revolution),
        .remain     (remain),
        .feed       (feed),
        .motor      (motor),
        .busy       (busy),
        .done       (done),
        .empty      (empty),
        .fault      (fault),
        .ovf        (ovf),
        .pending    (pending),
        .fed_count  (fed_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Wheel advances one position per enabled tick while the motor was on.
    task automatic wheel_step();
        feed = 1'b0;
        if (wheel_on && motor && en) begin
            pos = (pos + 1) % 16;
            if (pos == 4 && portions > 0) begin
                feed = 1'b1;
                portions--;
            end
        end
        revolution = wheel_on && (pos >= 8);
        remain     = (portions > 0);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        wheel_step();
    endtask

    task automatic pulse_req();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = done;
        end
        check(tag, seen, 1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req = 1'b0; auto_en = 1'b0; clr = 1'b0;
        feed = 1'b0; revolution = 1'b0; remain = 1'b1;

        // 1: reset state
        repeat (3) tick();
        check("rst_motor", motor, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_empty", empty, 0);
        check("rst_fault", fault, 0);
        check("rst_ovf", ovf, 0);
        check("rst_pending", pending, 0);
        check("rst_fed", fed_count, 0);
        rst = 1'b0;
        repeat (4) tick();
        check("idle_motor", motor, 0);

        // 2: single request, one portion, park at sensor rise
        pulse_req();
        check("s2_pending_q", pending, 1);
        tick();
        check("s2_motor_on", motor, 1);
        check("s2_busy", busy, 1);
        check("s2_pending_dq", pending, 0);
        wait_done("s2_done");
        check("s2_motor_off", motor, 0);
        check("s2_fed", fed_count, 1);
        tick();
        check("s2_done_1clk", done, 0);
        check("s2_pending", pending, 0);

        // 3: three requests with two portions -> empty, then refill
        portions = 2; remain = 1'b1;
        req = 1'b1;
        repeat (3) tick();
        req = 1'b0;
        check("s3_pending_q", pending, 2);
        wait_done("s3_done1");
        wait_done("s3_done2");
        check("s3_fed2", fed_count, 3);
        repeat (2) tick();
        check("s3_empty", empty, 1);
        check("s3_pending_kept", pending, 1);
        check("s3_motor_off", motor, 0);
        repeat (5) tick();
        check("s3_empty_hold", empty, 1);
        portions = 2; remain = 1'b1;
        wait_done("s3_done3");
        check("s3_fed3", fed_count, 4);
        check("s3_empty_clr", empty, 0);
        check("s3_pending0", pending, 0);

        // 4: stuck wheel -> timeout after 32 spinning ticks
        wheel_on = 1'b0; revolution = 1'b0;
        pulse_req();
        for (int i = 0; i < 60 && !faulted; i++) begin
            tick();
            if (fault) faulted = 1'b1;
            else if (motor) spin_ticks++;
        end
        check("s4_fault", faulted, 1);
        check("s4_spin_ticks", spin_ticks, 32);
        check("s4_motor_off", motor, 0);
        check("s4_busy_off", busy, 0);
        repeat (3) tick();
        check("s4_fault_hold", fault, 1);
        pulse_clr();
        check("s4_fault_clr", fault, 0);
        wheel_on = 1'b1;
        pulse_req();
        wait_done("s4_recover");
        check("s4_fed", fed_count, 5);

        // 5: requests while disabled overflow the queue
        tick();
        en = 1'b0; portions = 3; remain = 1'b1;
        repeat (5) begin
            req = 1'b1;
            tick();
            req = 1'b0;
            tick();
        end
        check("s5_pending_sat", pending, 3);
        check("s5_ovf", ovf, 1);
        check("s5_motor_frozen", motor, 0);
        en = 1'b1;
        wait_done("s5_done1");
        wait_done("s5_done2");
        wait_done("s5_done3");
        check("s5_fed", fed_count, 8);
        check("s5_pending0", pending, 0);
        check("s5_ovf_sticky", ovf, 1);
        pulse_clr();
        check("s5_ovf_clr", ovf, 0);

        // 6: interval timer fires on tick 39; reset mid-spin drops everything
        portions = 3; remain = 1'b1;
        auto_en = 1'b1;
        repeat (39) tick();
        check("s6_pre_fire", pending, 0);
        tick();
        check("s6_fire", pending, 1);
        check("s6_fire_idle", motor, 0);
        tick();
        check("s6_spin", motor, 1);
        check("s6_dispatched", pending, 0);
        pulse_req();
        check("s6_queued", pending, 1);
        rst = 1'b1;
        tick();
        check("s6_rst_motor", motor, 0);
        check("s6_rst_pending", pending, 0);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_fed", fed_count, 0);
        rst = 1'b0;
        repeat (39) tick();
        check("s6_reload", pending, 0);
        tick();
        check("s6_refire", pending, 1);
        auto_en = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
